sap_1_out_display: RTL and testbench
====================================

# sap_1_out_display

Output stage downstream of the SAP-1 core. It latches the byte the core drives out on its output-register load and converts it to three decimal digits with an iterative double-dabble engine. It then plays those digits one at a time on the single 7-segment display (`uo_out`), with leading-zero suppression and a blank gap between repetitions.

## Interface
Parameters:
- `DIGIT_TICKS`, default 5_000_000: clock cycles each digit is shown (≥2).
- `BLANK_TICKS`, default 2_500_000: clock cycles of blank display between repetitions (≥2).
- `CNT_W`, default 24: width of the dwell counter; must hold max(DIGIT_TICKS, BLANK_TICKS)−1.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `out_load` in 1: load strobe from the core; sampled every edge.
- `out_data` in 8: byte captured when `out_load`=1.
- `value` out 8: currently latched byte.
- `busy` out 1: conversion in progress.
- `seg` out 8: active-high segments; bit0=a … bit6=g, bit7=dp.

## Operation
- Reset (edge with `rst_n`=0):
  - `value`=0, BCD digits H/T/O = 0, converter idle, `busy`=0.
  - Sequencer in GAP with dwell counter 0, so `seg`=0x00.
- Load: an edge with `out_load`=1 captures `out_data` into `value`, sets `busy`=1 and clears the shift register. Load while `busy` restarts the conversion with the new byte (latest wins).
- Converter:
  - 8 shift cycles. Before each shift, any BCD nibble ≥5 gets +3. Then {H[1:0],T,O,bin} shifts left 1.
  - H is 2 bits (max 2).
  - On the 8th shift edge, H/T/O commit atomically and `busy` clears. The sequencer restarts at its first state with the dwell counter at 0.
- Sequencer states: SHOW_H → SHOW_T → SHOW_O → GAP → (first state).
  - SHOW_H is entered only if H≠0.
  - SHOW_T is entered only if H≠0 or T≠0.
  - SHOW_O is always entered; its dp=1, so ones are shown as "d.".
  - "First state" is the first enabled state.
  - Each SHOW state lasts DIGIT_TICKS cycles; GAP lasts BLANK_TICKS cycles.
  - The counter counts 0..N−1, then the state advances and the counter returns to 0.
- Decode (`seg`[6:0]): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Ones digit ORs in 0x80. GAP gives 0x00.
- `seg` is a combinational decode of registered state and digits; there is no extra pipeline stage.
- While `busy`, the sequencer keeps running on the old H/T/O; the display does not glitch to partial results.

## Timing
- Load sampled at edge N:
  - `value` and `busy`=1 are visible after N.
  - Shifts happen on N+1..N+8; commit at N+8.
  - `busy`=0 and `seg` shows the new first digit after edge N+8, for exactly DIGIT_TICKS cycles.
- Reload at edge N+k (1≤k≤8): completion moves to N+k+8; `busy` stays 1 continuously.
- Reset at any point, mid-conversion or mid-digit, wins over load and over the counter. Outputs take their reset values after that edge.
- `out_load` held high re-captures every cycle; `busy` never clears until it drops.

## Test plan
- Reset, then hold idle: `seg`=0x00 for BLANK_TICKS cycles, then 0xBF ("0.") for DIGIT_TICKS cycles, repeating. `value`=0, `busy`=0.
- Load 0xFF (DIGIT_TICKS=4, BLANK_TICKS=3): `busy` is high for edges N..N+7 and clears after N+8. `seg` sequence: 0x5B×4, 0x6D×4, 0xED×4, 0x00×3, then repeats.
- Load 0x07: the only digit is 0x87×DIGIT_TICKS, then 0x00×BLANK_TICKS. Load 0x64 (100): 0x06, 0x3F, 0xBF (zero tens shown).
- Load 0x0A: 0x06, then 0xBF (hundreds suppressed). Load 0x00: 0xBF only.
- Load 0x12, then load 0xC8 three cycles later: `busy` stays high continuously and clears 8 edges after the second load. The display moves from the old digits directly to 2,0,0. No intermediate value (e.g. 18) is ever shown.
- Assert `rst_n`=0 at shift cycle 4 of a conversion: after that edge `busy`=0, `value`=0, `seg`=0x00. The conversion is abandoned and the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/sap_1_out_display.sv
// SAP-1 output stage: latches the output byte, converts it to BCD with a serial
// double-dabble engine and plays the digits one at a time on a single 7-segment display.
module sap_1_out_display #(
   parameter int unsigned DIGIT_TICKS = 5_000_000,
   parameter int unsigned BLANK_TICKS = 2_500_000,
   parameter int unsigned CNT_W       = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       out_load,
   input  logic [7:0] out_data,
   output logic [7:0] value,
   output logic       busy,
   output logic [7:0] seg
);

   typedef enum logic [1:0] {StShowH, StShowT, StShowO, StGap} state_e;

   localparam logic [CNT_W-1:0] DigitLast = CNT_W'(DIGIT_TICKS - 1);
   localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_TICKS - 1);

   logic [7:0]       value_q;
   logic             busy_q;
   logic [2:0]       step_q;
   logic [7:0]       bin_q;
   logic [1:0]       wh_q;
   logic [3:0]       wt_q;
   logic [3:0]       wo_q;
   logic [1:0]       dig_h_q;
   logic [3:0]       dig_t_q;
   logic [3:0]       dig_o_q;
   state_e           state_q;
   logic [CNT_W-1:0] dwell_q;

   logic [3:0]       t_adj;
   logic [3:0]       o_adj;
   logic [17:0]      shift_out;
   logic             commit;
   logic [CNT_W-1:0] dwell_last;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      s = 7'h00;
      unique case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Leading-zero suppression: skip hundreds/tens while they are zero.
   function automatic state_e first_state(input logic [1:0] h, input logic [3:0] t);
      if (h != 2'd0) return StShowH;
      else if (t != 4'd0) return StShowT;
      else return StShowO;
   endfunction

   always_comb begin
      t_adj      = (wt_q >= 4'd5) ? wt_q + 4'd3 : wt_q;
      o_adj      = (wo_q >= 4'd5) ? wo_q + 4'd3 : wo_q;
      shift_out  = {wh_q[0], t_adj, o_adj, bin_q, 1'b0};
      commit     = busy_q && !out_load && (step_q == 3'd7);
      dwell_last = (state_q == StGap) ? BlankLast : DigitLast;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_q <= 8'h00;
         busy_q  <= 1'b0;
         step_q  <= 3'd0;
         bin_q   <= 8'h00;
         wh_q    <= 2'd0;
         wt_q    <= 4'd0;
         wo_q    <= 4'd0;
         dig_h_q <= 2'd0;
         dig_t_q <= 4'd0;
         dig_o_q <= 4'd0;
         state_q <= StGap;
         dwell_q <= '0;
      end else begin
         if (out_load) begin
            value_q <= out_data;
            bin_q   <= out_data;
            wh_q    <= 2'd0;
            wt_q    <= 4'd0;
            wo_q    <= 4'd0;
            step_q  <= 3'd0;
            busy_q  <= 1'b1;
         end else if (busy_q) begin
            {wh_q, wt_q, wo_q, bin_q} <= shift_out;
            step_q <= step_q + 3'd1;
            if (step_q == 3'd7) begin
               busy_q  <= 1'b0;
               dig_h_q <= shift_out[17:16];
               dig_t_q <= shift_out[15:12];
               dig_o_q <= shift_out[11:8];
            end
         end

         // Fresh digits restart the sequence so the new number is shown from its start.
         if (commit) begin
            state_q <= first_state(shift_out[17:16], shift_out[15:12]);
            dwell_q <= '0;
         end else if (dwell_q == dwell_last) begin
            dwell_q <= '0;
            unique case (state_q)
               StShowH: state_q <= StShowT;
               StShowT: state_q <= StShowO;
               StShowO: state_q <= StGap;
               StGap:   state_q <= first_state(dig_h_q, dig_t_q);
            endcase
         end else begin
            dwell_q <= dwell_q + 1'b1;
         end
      end
   end

   always_comb begin
      seg = 8'h00;
      unique case (state_q)
         StShowH: seg = {1'b0, decode({2'b00, dig_h_q})};
         StShowT: seg = {1'b0, decode(dig_t_q)};
         StShowO: seg = {1'b1, decode(dig_o_q)};
         StGap:   seg = 8'h00;
      endcase
   end

   assign value = value_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_sap_1_out_display.sv
// Directed bench for sap_1_out_display with short dwell times (4 digit / 3 blank cycles).
module tb_sap_1_out_display;

   localparam int unsigned DT = 4;
   localparam int unsigned BT = 3;

   typedef logic [7:0] byte_q_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       out_load = 1'b0;
   logic [7:0] out_data = 8'h00;
   logic [7:0] value;
   logic       busy;
   logic [7:0] seg;

   int n_cmp = 0;
   int n_err = 0;

   sap_1_out_display #(
      .DIGIT_TICKS(DT),
      .BLANK_TICKS(BT),
      .CNT_W      (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .out_load(out_load),
      .out_data(out_data),
      .value   (value),
      .busy    (busy),
      .seg     (seg)
   );

   always #5 clk = ~clk;

   // Each digit code held DT cycles, then BT blank cycles, then the first code again.
   function automatic byte_q_t expand(input byte_q_t codes);
      byte_q_t q;
      foreach (codes[k]) for (int r = 0; r < int'(DT); r++) q.push_back(codes[k]);
      for (int r = 0; r < int'(BT); r++) q.push_back(8'h00);
      q.push_back(codes[0]);
      return q;
   endfunction

   // Blank for BT cycles from the reset edge, then "0." for DT, blank, "0." again.
   function automatic byte_q_t reset_seq();
      byte_q_t q;
      for (int r = 0; r < int'(BT); r++) q.push_back(8'h00);
      for (int r = 0; r < int'(DT); r++) q.push_back(8'hBF);
      for (int r = 0; r < int'(BT); r++) q.push_back(8'h00);
      q.push_back(8'hBF);
      return q;
   endfunction

   task automatic test_reset();
      byte_q_t e;
      rst_n = 1'b0;
      out_load = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (value !== 8'h00) begin
         n_err++; $display("FAIL reset_value: got %02h expected 00", value);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      rst_n = 1'b1;
      e = reset_seq();
      for (int i = 0; i < e.size(); i++) begin
         if (i != 0) @(negedge clk);
         n_cmp++;
         if (seg !== e[i]) begin
            n_err++; $display("FAIL reset_seg[%0d]: got %02h expected %02h", i, seg, e[i]);
         end
      end
   endtask

   task automatic test_load_ff();
      byte_q_t e;
      @(negedge clk);
      out_load = 1'b1; out_data = 8'hFF;
      @(negedge clk);
      out_load = 1'b0;
      n_cmp++;
      if (value !== 8'hFF || busy !== 1'b1) begin
         n_err++; $display("FAIL ff_load: got value %02h busy %b expected FF 1", value, busy);
      end
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b1) begin
            n_err++; $display("FAIL ff_busy_n%0d: got %b expected 1", k, busy);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL ff_busy_done: got %b expected 0", busy);
      end
      e = expand('{8'h5B, 8'h6D, 8'hED});
      for (int i = 0; i < e.size(); i++) begin
         if (i != 0) @(negedge clk);
         n_cmp++;
         if (seg !== e[i]) begin
            n_err++; $display("FAIL ff_seg[%0d]: got %02h expected %02h", i, seg, e[i]);
         end
      end
   endtask

   task automatic test_suppression();
      logic [7:0] vec_d[4] = '{8'h07, 8'h64, 8'h0A, 8'h00};
      byte_q_t    codes;
      byte_q_t    e;
      for (int v = 0; v < 4; v++) begin
         case (v)
            0: codes = '{8'h87};
            1: codes = '{8'h06, 8'h3F, 8'hBF};
            2: codes = '{8'h06, 8'hBF};
            default: codes = '{8'hBF};
         endcase
         @(negedge clk);
         out_load = 1'b1; out_data = vec_d[v];
         @(negedge clk);
         out_load = 1'b0;
         n_cmp++;
         if (value !== vec_d[v] || busy !== 1'b1) begin
            n_err++;
            $display("FAIL sup_load_%02h: got value %02h busy %b expected %02h 1",
                     vec_d[v], value, busy, vec_d[v]);
         end
         repeat (8) @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0) begin
            n_err++; $display("FAIL sup_busy_%02h: got %b expected 0", vec_d[v], busy);
         end
         e = expand(codes);
         for (int i = 0; i < e.size(); i++) begin
            if (i != 0) @(negedge clk);
            n_cmp++;
            if (seg !== e[i]) begin
               n_err++;
               $display("FAIL sup_%02h_seg[%0d]: got %02h expected %02h", vec_d[v], i, seg, e[i]);
            end
         end
      end
   endtask

   // Previous test leaves digits 0/0/0, so only blank or "0." may appear while busy.
   task automatic test_back_to_back();
      byte_q_t e;
      @(negedge clk);
      out_load = 1'b1; out_data = 8'h12;
      @(negedge clk);
      out_load = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (busy !== 1'b1 || (seg !== 8'h00 && seg !== 8'hBF)) begin
            n_err++; $display("FAIL b2b_first_%0d: got busy %b seg %02h expected 1 00/BF", k, busy, seg);
         end
         if (k == 0) @(negedge clk);
      end
      @(negedge clk);
      out_load = 1'b1; out_data = 8'hC8;
      @(negedge clk);
      out_load = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k != 0) @(negedge clk);
         n_cmp++;
         if (busy !== 1'b1 || (seg !== 8'h00 && seg !== 8'hBF)) begin
            n_err++; $display("FAIL b2b_hold_%0d: got busy %b seg %02h expected 1 00/BF", k, busy, seg);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || value !== 8'hC8) begin
         n_err++; $display("FAIL b2b_done: got busy %b value %02h expected 0 C8", busy, value);
      end
      e = expand('{8'h5B, 8'h3F, 8'hBF});
      for (int i = 0; i < e.size(); i++) begin
         if (i != 0) @(negedge clk);
         n_cmp++;
         if (seg !== e[i]) begin
            n_err++; $display("FAIL b2b_seg[%0d]: got %02h expected %02h", i, seg, e[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      byte_q_t e;
      @(negedge clk);
      out_load = 1'b1; out_data = 8'hFF;
      @(negedge clk);
      out_load = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if (busy !== 1'b0 || value !== 8'h00) begin
         n_err++; $display("FAIL mid_reset: got busy %b value %02h expected 0 00", busy, value);
      end
      e = reset_seq();
      for (int i = 0; i < e.size(); i++) begin
         if (i != 0) @(negedge clk);
         n_cmp++;
         if (seg !== e[i]) begin
            n_err++; $display("FAIL mid_seg[%0d]: got %02h expected %02h", i, seg, e[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_ff();
      test_suppression();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
